// File: rtl/noc_mem_responder_pkg.sv
// rtl/noc_mem_responder_pkg.sv - shared types, opcodes and helpers for the NOC memory responder
// Contents:
//   opcode / error-reason constants, packet length constants,
//   responder state enum, packed header struct, line type,
//   pack_hdr(): builds the 8-byte packet header from a header struct and byte address.
package noc_mem_responder_pkg;

    localparam int LINE_BYTES = 16;

    localparam logic [7:0] OP_RD     = 8'h01;
    localparam logic [7:0] OP_WR     = 8'h02;
    localparam logic [7:0] OP_RD_RSP = 8'h81;
    localparam logic [7:0] OP_WR_ACK = 8'h82;
    localparam logic [7:0] OP_ERR    = 8'hFF;

    localparam logic [7:0] ERR_NONE   = 8'd0;
    localparam logic [7:0] ERR_OPCODE = 8'd1;
    localparam logic [7:0] ERR_SHORT  = 8'd2;
    localparam logic [7:0] ERR_RANGE  = 8'd3;

    // Bytes present for a header-only packet and for a header plus one line.
    localparam logic [5:0] BP_HDR  = 6'd8;
    localparam logic [5:0] BP_LINE = 6'd24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_MEM,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [3:0] src_addr;
        logic [3:0] dst_addr;
        logic [3:0] src_port;
        logic [3:0] dst_port;
        logic [7:0] opcode;
        logic [7:0] reason;
    } noc_hdr_t;

    typedef logic [LINE_BYTES-1:0][7:0] line_t;

    // Byte 0/1 carry {src, dst} nibbles; bytes 4-7 hold the address little-endian.
    function automatic logic [7:0][7:0] pack_hdr(input noc_hdr_t h, input logic [31:0] addr);
        logic [7:0][7:0] b;
        b[0]   = {h.src_addr, h.dst_addr};
        b[1]   = {h.src_port, h.dst_port};
        b[2]   = h.opcode;
        b[3]   = h.reason;
        b[7:4] = addr;
        return b;
    endfunction

endpackage

// File: rtl/noc_line_ram.sv
// rtl/noc_line_ram.sv - single-port DEPTH x 128-bit synchronous line RAM
// Ports:
//   clk_i    clock
//   we_i     write enable; writes wdata_i to line addr_i on the clock edge
//   addr_i   line index
//   wdata_i  line write data
//   rdata_o  registered read data of line addr_i (value before any same-edge write)
// Contents are not reset.
module noc_line_ram
    import noc_mem_responder_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  line_t                    wdata_i,
    output line_t                    rdata_o
);

    line_t mem [DEPTH];
    line_t rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/noc_mem_responder.sv
// rtl/noc_mem_responder.sv - NOC memory-side endpoint serving line read/write requests
// Ports:
//   cclk             clock
//   rst              asynchronous active-high reset
//   noc_bus_inp_dat  inbound packet bytes
//   noc_bus_inp_bp   inbound bytes-present count, 0 = no packet
//   noc_bus_inp_bo   inbound busy, high in every state but IDLE
//   noc_bus_oup_dat  outbound response bytes
//   noc_bus_oup_bp   outbound bytes-present count
//   noc_bus_oup_bo   outbound busy from downstream
// One request is handled at a time: IDLE -> CHECK -> (MEM) -> RESP -> IDLE.
module noc_mem_responder
    import noc_mem_responder_pkg::*;
#(
    parameter logic [3:0] MY_ADDR = 4'h1,
    parameter logic [3:0] MY_PORT = 4'h0,
    parameter int         DEPTH   = 256,
    parameter int         MEM_LAT = 2
) (
    input  logic             cclk,
    input  logic             rst,
    input  logic [31:0][7:0] noc_bus_inp_dat,
    input  logic [5:0]       noc_bus_inp_bp,
    output logic             noc_bus_inp_bo,
    output logic [31:0][7:0] noc_bus_oup_dat,
    output logic [5:0]       noc_bus_oup_bp,
    input  logic             noc_bus_oup_bo
);

    localparam int AW = $clog2(DEPTH);

    state_e           state_q,   state_d;
    noc_hdr_t         hdr_q,     hdr_d;
    logic [31:0]      addr_q,    addr_d;
    line_t            line_q,    line_d;
    logic [5:0]       req_bp_q,  req_bp_d;
    logic [3:0]       cnt_q,     cnt_d;
    logic [31:0][7:0] oup_dat_q, oup_dat_d;
    logic [5:0]       oup_bp_q,  oup_bp_d;

    logic      is_rd;
    logic      is_wr;
    logic      ram_we;
    line_t     ram_rdata;
    logic [7:0] err_reason;
    noc_hdr_t  rsp_hdr;
    logic      unused_inp;

    // Byte 3 and bytes 24-31 of a request carry nothing this endpoint needs.
    assign unused_inp = ^{noc_bus_inp_dat[31:24], noc_bus_inp_dat[3]};

    assign is_rd = (hdr_q.opcode == OP_RD);
    assign is_wr = (hdr_q.opcode == OP_WR);

    // Error priority: bad opcode, then short packet, then address out of range.
    // The range test covers both the index limit and any nonzero upper bits.
    always_comb begin
        err_reason = ERR_NONE;
        if (!is_rd && !is_wr) begin
            err_reason = ERR_OPCODE;
        end else if ((is_rd && (req_bp_q < BP_HDR)) || (is_wr && (req_bp_q < BP_LINE))) begin
            err_reason = ERR_SHORT;
        end else if ((addr_q >> 4) >= 32'(DEPTH)) begin
            err_reason = ERR_RANGE;
        end
    end

    noc_line_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk_i  (cclk),
        .we_i   (ram_we),
        .addr_i (addr_q[4 +: AW]),
        .wdata_i(line_q),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        state_d        = state_q;
        hdr_d          = hdr_q;
        addr_d         = addr_q;
        line_d         = line_q;
        req_bp_d       = req_bp_q;
        cnt_d          = cnt_q;
        oup_dat_d      = oup_dat_q;
        oup_bp_d       = oup_bp_q;
        ram_we         = 1'b0;
        noc_bus_inp_bo = 1'b1;

        rsp_hdr          = '0;
        rsp_hdr.src_addr = MY_ADDR;
        rsp_hdr.dst_addr = hdr_q.src_addr;
        rsp_hdr.src_port = MY_PORT;
        rsp_hdr.dst_port = hdr_q.src_port;
        rsp_hdr.reason   = hdr_q.reason;
        rsp_hdr.opcode   = (hdr_q.reason != ERR_NONE) ? OP_ERR :
                           (is_rd ? OP_RD_RSP : OP_WR_ACK);

        unique case (state_q)
            ST_IDLE: begin
                noc_bus_inp_bo = 1'b0;
                if (noc_bus_inp_bp != '0) begin
                    hdr_d.src_addr = noc_bus_inp_dat[0][7:4];
                    hdr_d.dst_addr = noc_bus_inp_dat[0][3:0];
                    hdr_d.src_port = noc_bus_inp_dat[1][7:4];
                    hdr_d.dst_port = noc_bus_inp_dat[1][3:0];
                    hdr_d.opcode   = noc_bus_inp_dat[2];
                    hdr_d.reason   = ERR_NONE;
                    addr_d         = noc_bus_inp_dat[7:4];
                    line_d         = noc_bus_inp_dat[23:8];
                    req_bp_d       = noc_bus_inp_bp;
                    state_d        = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if ((hdr_q.dst_addr != MY_ADDR) || (hdr_q.dst_port != MY_PORT)) begin
                    state_d = ST_IDLE;
                end else if (err_reason != ERR_NONE) begin
                    hdr_d.reason = err_reason;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d   = 4'(MEM_LAT);
                    state_d = ST_MEM;
                end
            end

            ST_MEM: begin
                // The write is tied to the single MEM->RESP edge, so it fires once per WR.
                if (cnt_q == 4'd1) begin
                    ram_we  = is_wr;
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RESP: begin
                // First RESP cycle builds the response (RAM read data is valid by then);
                // afterwards it is held until downstream takes it.
                if (oup_bp_q == '0) begin
                    oup_dat_d      = '0;
                    oup_dat_d[7:0] = pack_hdr(rsp_hdr, addr_q);
                    if ((hdr_q.reason == ERR_NONE) && is_rd) begin
                        oup_dat_d[23:8] = ram_rdata;
                        oup_bp_d        = BP_LINE;
                    end else begin
                        oup_bp_d = BP_HDR;
                    end
                end else if (!noc_bus_oup_bo) begin
                    oup_bp_d = '0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hdr_q     <= '0;
            addr_q    <= '0;
            line_q    <= '0;
            req_bp_q  <= '0;
            cnt_q     <= '0;
            oup_dat_q <= '0;
            oup_bp_q  <= '0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
            req_bp_q  <= req_bp_d;
            cnt_q     <= cnt_d;
            oup_dat_q <= oup_dat_d;
            oup_bp_q  <= oup_bp_d;
        end
    end

    assign noc_bus_oup_dat = oup_dat_q;
    assign noc_bus_oup_bp  = oup_bp_q;

endmodule

// File: tb/tb_noc_mem_responder.sv
// tb/tb_noc_mem_responder.sv - randomized self-checking bench for noc_mem_responder
module tb_noc_mem_responder;

    localparam logic [3:0] MY_A    = 4'h1;
    localparam logic [3:0] MY_P    = 4'h0;
    localparam int         DEPTH   = 256;
    localparam int         MEM_LAT = 2;

    logic             cclk = 1'b0;
    logic             rst;
    logic [31:0][7:0] inp_dat;
    logic [5:0]       inp_bp;
    logic             inp_bo;
    logic [31:0][7:0] oup_dat;
    logic [5:0]       oup_bp;
    logic             oup_bo;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    logic [127:0] mdl [DEPTH];

    noc_mem_responder #(
        .MY_ADDR(MY_A),
        .MY_PORT(MY_P),
        .DEPTH  (DEPTH),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .cclk           (cclk),
        .rst            (rst),
        .noc_bus_inp_dat(inp_dat),
        .noc_bus_inp_bp (inp_bp),
        .noc_bus_inp_bo (inp_bo),
        .noc_bus_oup_dat(oup_dat),
        .noc_bus_oup_bp (oup_bp),
        .noc_bus_oup_bo (oup_bo)
    );

    always #5 cclk = ~cclk;
    always @(posedge cclk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_pkt(input logic [3:0] sa, input logic [3:0] sp,
                                            input logic [3:0] da, input logic [3:0] dp,
                                            input logic [7:0] op, input logic [31:0] addr,
                                            input logic [127:0] data);
        logic [31:0][7:0] p;
        p    = '0;
        p[0] = {sa, da};
        p[1] = {sp, dp};
        p[2] = op;
        for (int i = 0; i < 4; i++)  p[4+i] = addr[8*i +: 8];
        for (int i = 0; i < 16; i++) p[8+i] = data[8*i +: 8];
        return p;
    endfunction

    // Reference: what the endpoint must answer for one request, applied in order.
    task automatic model(input logic [3:0] sa, input logic [3:0] sp, input logic [3:0] da,
                         input logic [3:0] dp, input logic [7:0] op, input logic [31:0] addr,
                         input logic [127:0] data, input int bp, output bit resp,
                         output logic [255:0] edat, output int ebp, output int elat);
        int           reason;
        int           line;
        logic [7:0]   rop;
        logic [127:0] rdata;
        resp   = (da == MY_A) && (dp == MY_P);
        reason = 0;
        rdata  = '0;
        line   = int'(addr >> 4);
        if (op != 8'h01 && op != 8'h02)                 reason = 1;
        else if (bp < ((op == 8'h01) ? 8 : 24))         reason = 2;
        else if ((addr >> 4) >= 32'(DEPTH))             reason = 3;
        if (reason != 0) begin
            rop = 8'hFF; ebp = 8; elat = 2;
        end else if (op == 8'h01) begin
            rop = 8'h81; ebp = 24; elat = MEM_LAT + 2; rdata = mdl[line];
        end else begin
            rop = 8'h82; ebp = 8; elat = MEM_LAT + 2;
            if (resp) mdl[line] = data;
        end
        edat        = mk_pkt(MY_A, MY_P, sa, sp, rop, addr, rdata);
        edat[31:24] = 8'(reason);
    endtask

    task automatic send_pkt(input logic [255:0] pkt, input logic [5:0] bp, output int acc);
        int w;
        w = 0;
        @(negedge cclk);
        inp_dat = pkt;
        inp_bp  = bp;
        while (inp_bo && w < 200) begin
            @(negedge cclk);
            w++;
        end
        if (inp_bo) check_eq("send_timeout", 256'(inp_bo), 256'(0));
        @(posedge cclk);
        #1;
        acc     = cyc;
        inp_bp  = '0;
        inp_dat = '0;
    endtask

    task automatic recv_pkt(input string tag, input int hold, output logic [255:0] dat,
                            output logic [5:0] bp, output int vcyc, output int tcyc);
        int w;
        w      = 0;
        oup_bo = (hold > 0);
        while (oup_bp == '0 && w < 200) begin
            @(negedge cclk);
            w++;
        end
        vcyc = cyc;
        dat  = oup_dat;
        bp   = oup_bp;
        if (oup_bp == '0) begin
            check_eq($sformatf("%s_resp_timeout", tag), 256'(oup_bp != '0), 256'(1));
            oup_bo = 1'b0;
            tcyc   = cyc;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge cclk);
            check_eq($sformatf("%s_hold_dat", tag), oup_dat, dat);
            check_eq($sformatf("%s_hold_bp", tag), 256'(oup_bp), 256'(bp));
            check_eq($sformatf("%s_hold_ibo", tag), 256'(inp_bo), 256'(1));
        end
        oup_bo = 1'b0;
        @(posedge cclk);
        #1;
        tcyc = cyc;
        check_eq($sformatf("%s_bp_clr", tag), 256'(oup_bp), 256'(0));
        check_eq($sformatf("%s_ibo_after", tag), 256'(inp_bo), 256'(0));
    endtask

    task automatic do_txn(input string tag, input logic [3:0] sa, input logic [3:0] sp,
                          input logic [3:0] da, input logic [3:0] dp, input logic [7:0] op,
                          input logic [31:0] addr, input logic [127:0] data, input int bp,
                          input int hold);
        bit           resp;
        logic [255:0] edat;
        logic [255:0] gdat;
        logic [5:0]   gbp;
        int           ebp, elat, acc, vcyc, tcyc, seen;
        model(sa, sp, da, dp, op, addr, data, bp, resp, edat, ebp, elat);
        send_pkt(mk_pkt(sa, sp, da, dp, op, addr, data), 6'(bp), acc);
        @(negedge cclk);
        check_eq($sformatf("%s_ibo_check", tag), 256'(inp_bo), 256'(1));
        if (!resp) begin
            seen = 0;
            @(negedge cclk);
            check_eq($sformatf("%s_ibo_drop", tag), 256'(inp_bo), 256'(0));
            repeat (20) begin
                if (oup_bp != '0) seen++;
                @(negedge cclk);
            end
            check_eq($sformatf("%s_no_resp", tag), 256'(seen), 256'(0));
        end else begin
            recv_pkt(tag, hold, gdat, gbp, vcyc, tcyc);
            check_eq($sformatf("%s_dat", tag), gdat, edat);
            check_eq($sformatf("%s_bp", tag), 256'(gbp), 256'(ebp));
            check_eq($sformatf("%s_lat", tag), 256'(vcyc - acc), 256'(elat));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] seq16;
        logic [255:0] gdat;
        logic [5:0]   gbp;
        logic [255:0] edat_a, edat_b;
        bit           resp;
        int           ebp_a, ebp_b, elat_a, elat_b, acc_a, acc_b, v_a, v_b, t_a, t_b, acc;
        int           r, line, bp;
        logic [7:0]   op;
        logic [3:0]   da, dp;
        logic [31:0]  addr;

        rst     = 1'b1;
        inp_dat = '0;
        inp_bp  = '0;
        oup_bo  = 1'b0;
        seq16   = 128'h0f0e0d0c0b0a09080706050403020100;
        repeat (3) @(negedge cclk);
        rst = 1'b0;
        @(negedge cclk);
        check_eq("rst_inp_bo", 256'(inp_bo), 256'(0));
        check_eq("rst_oup_bp", 256'(oup_bp), 256'(0));
        check_eq("rst_oup_dat", oup_dat, 256'(0));

        do_txn("wr40", 4'h2, 4'h0, MY_A, MY_P, 8'h02, 32'h40, seq16, 24, 0);
        do_txn("rd40", 4'h2, 4'h0, MY_A, MY_P, 8'h01, 32'h40, '0, 8, 0);
        do_txn("drop", 4'h2, 4'h0, 4'h3, MY_P, 8'h01, 32'h40, '0, 8, 0);
        do_txn("err_op", 4'h5, 4'h3, MY_A, MY_P, 8'h07, 32'h40, '0, 24, 0);
        do_txn("err_rng", 4'h2, 4'h1, MY_A, MY_P, 8'h01, 32'(DEPTH) << 4, '0, 8, 0);
        do_txn("err_short", 4'h2, 4'h0, MY_A, MY_P, 8'h02, 32'h40, {16{8'hEE}}, 8, 0);
        do_txn("err_upper", 4'h2, 4'h0, MY_A, MY_P, 8'h01, 32'h1000_0040, '0, 8, 0);
        do_txn("rd40_again", 4'h2, 4'h0, MY_A, MY_P, 8'h01, 32'h40, '0, 24, 0);
        do_txn("wr_last", 4'h4, 4'h2, MY_A, MY_P, 8'h02, 32'(DEPTH - 1) << 4, ~seq16, 24, 0);
        do_txn("rd_last", 4'h4, 4'h2, MY_A, MY_P, 8'h01, 32'(DEPTH - 1) << 4, '0, 8, 0);
        do_txn("rd_hold", 4'h2, 4'h0, MY_A, MY_P, 8'h01, 32'h40, '0, 24, 10);

        // Second request presented while the first is in MEM.
        model(4'h6, 4'h1, MY_A, MY_P, 8'h02, 32'h50, ~seq16 ^ seq16 << 8, 24, resp, edat_a, ebp_a, elat_a);
        model(4'h7, 4'h2, MY_A, MY_P, 8'h01, 32'h50, '0, 8, resp, edat_b, ebp_b, elat_b);
        fork
            begin
                send_pkt(mk_pkt(4'h6, 4'h1, MY_A, MY_P, 8'h02, 32'h50, ~seq16 ^ seq16 << 8), 6'd24, acc_a);
                send_pkt(mk_pkt(4'h7, 4'h2, MY_A, MY_P, 8'h01, 32'h50, '0), 6'd8, acc_b);
            end
            begin
                recv_pkt("b2b_a", 0, gdat, gbp, v_a, t_a);
                check_eq("b2b_a_dat", gdat, edat_a);
                check_eq("b2b_a_bp", 256'(gbp), 256'(ebp_a));
                recv_pkt("b2b_b", 0, gdat, gbp, v_b, t_b);
                check_eq("b2b_b_dat", gdat, edat_b);
                check_eq("b2b_b_bp", 256'(gbp), 256'(ebp_b));
            end
        join
        check_eq("b2b_a_lat", 256'(v_a - acc_a), 256'(elat_a));
        check_eq("b2b_b_accept", 256'(acc_b), 256'(t_a + 1));
        check_eq("b2b_b_lat", 256'(v_b - acc_b), 256'(elat_b));

        // Reset while a WR sits in MEM: nothing may be committed.
        do_txn("pre80", 4'h2, 4'h0, MY_A, MY_P, 8'h02, 32'h80, {16{8'hAA}}, 24, 0);
        send_pkt(mk_pkt(4'h2, 4'h0, MY_A, MY_P, 8'h02, 32'h80, {16{8'h55}}), 6'd24, acc);
        @(negedge cclk);
        @(negedge cclk);
        check_eq("mid_ibo_mem", 256'(inp_bo), 256'(1));
        rst = 1'b1;
        #1;
        check_eq("mid_rst_bp", 256'(oup_bp), 256'(0));
        check_eq("mid_rst_dat", oup_dat, 256'(0));
        check_eq("mid_rst_ibo", 256'(inp_bo), 256'(0));
        repeat (3) @(negedge cclk);
        rst = 1'b0;
        do_txn("rd80", 4'h2, 4'h0, MY_A, MY_P, 8'h01, 32'h80, '0, 24, 0);

        // Fill a small line pool so random reads always hit known content.
        for (int i = 0; i < 16; i++) begin
            do_txn("fill", 4'($urandom), 4'($urandom), MY_A, MY_P, 8'h02, 32'(i) << 4,
                   {$urandom, $urandom, $urandom, $urandom}, 24, 0);
        end

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40)      op = 8'h01;
            else if (r < 80) op = 8'h02;
            else             op = 8'($urandom_range(3, 255));
            line = int'($urandom_range(0, 15));
            addr = {20'h0, 8'(line), 4'($urandom)};
            if ($urandom_range(0, 9) == 0) addr = 32'($urandom_range(DEPTH, 4095)) << 4;
            bp = 24;
            if ($urandom_range(0, 6) == 0) bp = int'($urandom_range(1, (op == 8'h01) ? 7 : 23));
            else if (op == 8'h01) bp = int'($urandom_range(8, 32));
            da = MY_A;
            dp = MY_P;
            if ($urandom_range(0, 9) == 0) da = MY_A ^ 4'($urandom_range(1, 15));
            if ($urandom_range(0, 14) == 0) dp = MY_P ^ 4'($urandom_range(1, 15));
            do_txn($sformatf("rnd%0d", n), 4'($urandom), 4'($urandom), da, dp, op, addr,
                   {$urandom, $urandom, $urandom, $urandom}, bp, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
